// File: rtl/fdiv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fdiv_seq_ctrl
//
// Sequencing wrapper around a free-running, fixed-latency IEEE-754 single
// precision divider pipeline. Requests are accepted under a credit rule that
// reserves a result-buffer slot for every operation in flight, so results are
// never dropped even though the divider itself cannot stall. Special operand
// combinations (NaN, infinity, zero, denormal-as-zero) are resolved at accept
// time and carried alongside the op; ordinary ops take the divider result and
// get overflow/underflow flags derived from its exponent.
//
// Parameters
//   DIV_LAT     cycles from operands on div_a/div_b to valid div_res
//   TAG_W       destination-register tag width
//   OBUF_DEPTH  result buffer entries (power of two, >= 2)
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-low reset
//   flush       kill all in-flight and buffered ops
//   in_valid    request valid
//   in_ready    request accepted when in_valid && in_ready
//   in_a        dividend (IEEE-754 single)
//   in_b        divisor  (IEEE-754 single)
//   in_tag      destination tag
//   div_a       operand A to the divider pipeline (copy of in_a)
//   div_b       operand B to the divider pipeline (copy of in_b)
//   div_res     divider pipeline result
//   out_valid   head of result buffer valid
//   out_ready   consumer takes head when out_valid && out_ready
//   out_res     final result
//   out_tag     tag of out_res
//   out_fflags  exception flags {NV,DZ,OF,UF,NX}
// ---------------------------------------------------------------------------
module fdiv_seq_ctrl #(
    parameter int DIV_LAT    = 5,
    parameter int TAG_W      = 5,
    parameter int OBUF_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      div_a,
    output logic [31:0]      div_b,
    input  logic [31:0]      div_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       out_fflags
);

    // Counter width must hold the value OBUF_DEPTH itself (buffer full).
    localparam int CNT_W = $clog2(OBUF_DEPTH + 1);
    localparam int PTR_W = $clog2(OBUF_DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(OBUF_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Flag bit positions within {NV,DZ,OF,UF,NX}.
    localparam int F_NV = 4;
    localparam int F_DZ = 3;
    localparam int F_OF = 2;
    localparam int F_UF = 1;
    localparam int F_NX = 0;

    // -----------------------------------------------------------------------
    // Declarations
    // -----------------------------------------------------------------------
    logic             accept;
    logic [CNT_W-1:0] inflight_cnt;
    logic [CNT_W-1:0] obuf_cnt;
    logic [CNT_W:0]   credit_sum;

    // Operand classification
    logic a_exp_max, a_exp_zero, a_man_nz;
    logic b_exp_max, b_exp_zero, b_man_nz;
    logic a_nan, a_snan, a_inf, a_zero;
    logic b_nan, b_snan, b_inf, b_zero;
    logic res_sign;

    logic        dec_special;
    logic [31:0] dec_res;
    logic [4:0]  dec_flags;

    // Latency-matching shift register
    logic             sr_valid   [DIV_LAT];
    logic [TAG_W-1:0] sr_tag     [DIV_LAT];
    logic             sr_special [DIV_LAT];
    logic [31:0]      sr_res     [DIV_LAT];
    logic [4:0]       sr_flags   [DIV_LAT];

    logic             ex_valid;
    logic [31:0]      ex_res;
    logic [4:0]       ex_flags;
    logic [TAG_W-1:0] ex_tag;

    // Result buffer
    logic [31:0]      mem_res   [OBUF_DEPTH];
    logic [TAG_W-1:0] mem_tag   [OBUF_DEPTH];
    logic [4:0]       mem_flags [OBUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             obuf_full;
    logic             push;
    logic             pop;

    // -----------------------------------------------------------------------
    // Divider operands are a straight pass-through; the divider never stalls.
    // -----------------------------------------------------------------------
    assign div_a = in_a;
    assign div_b = in_b;

    // -----------------------------------------------------------------------
    // Credit rule: every op in flight already owns a buffer slot, so the sum
    // of in-flight and buffered ops may never exceed the buffer depth.
    // -----------------------------------------------------------------------
    assign credit_sum = {1'b0, inflight_cnt} + {1'b0, obuf_cnt};
    assign in_ready   = rst && !flush && (credit_sum < {1'b0, DEPTH_CNT});
    assign accept     = in_valid && in_ready;

    // -----------------------------------------------------------------------
    // Operand classification. Denormals are treated as zero of the same sign,
    // so "zero" only looks at the exponent field.
    // -----------------------------------------------------------------------
    assign a_exp_max  = &in_a[30:23];
    assign a_exp_zero = ~|in_a[30:23];
    assign a_man_nz   = |in_a[22:0];
    assign b_exp_max  = &in_b[30:23];
    assign b_exp_zero = ~|in_b[30:23];
    assign b_man_nz   = |in_b[22:0];

    assign a_nan  = a_exp_max & a_man_nz;
    assign a_snan = a_nan & ~in_a[22];
    assign a_inf  = a_exp_max & ~a_man_nz;
    assign a_zero = a_exp_zero;
    assign b_nan  = b_exp_max & b_man_nz;
    assign b_snan = b_nan & ~in_b[22];
    assign b_inf  = b_exp_max & ~b_man_nz;
    assign b_zero = b_exp_zero;

    assign res_sign = in_a[31] ^ in_b[31];

    // -----------------------------------------------------------------------
    // Special-case decode. Order matters: NaN inputs dominate, then the
    // invalid forms, then infinite dividend (so inf/0 yields inf without DZ),
    // then divide-by-zero, then the zero-result cases.
    // -----------------------------------------------------------------------
    always_comb begin
        dec_special = 1'b1;
        dec_res     = '0;
        dec_flags   = '0;
        if (a_nan || b_nan) begin
            dec_res         = QNAN;
            dec_flags[F_NV] = a_snan | b_snan;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            dec_res         = QNAN;
            dec_flags[F_NV] = 1'b1;
        end else if (a_inf) begin
            dec_res = {res_sign, 8'hFF, 23'h0};
        end else if (b_zero) begin
            dec_res         = {res_sign, 8'hFF, 23'h0};
            dec_flags[F_DZ] = 1'b1;
        end else if (b_inf || a_zero) begin
            dec_res = {res_sign, 31'h0};
        end else begin
            dec_special = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Shift register valid bits: reset and flush kill every op in flight.
    // Stage k holds the op accepted k+1 edges ago, so the last stage lines
    // up with div_res for that op.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            for (int i = 0; i < DIV_LAT; i++) begin
                sr_valid[i] <= 1'b0;
            end
        end else begin
            sr_valid[0] <= accept;
            for (int i = 1; i < DIV_LAT; i++) begin
                sr_valid[i] <= sr_valid[i-1];
            end
        end
    end

    // Shift register payload needs no reset; it is qualified by sr_valid.
    always_ff @(posedge clk) begin
        sr_tag[0]     <= in_tag;
        sr_special[0] <= dec_special;
        sr_res[0]     <= dec_res;
        sr_flags[0]   <= dec_flags;
        for (int i = 1; i < DIV_LAT; i++) begin
            sr_tag[i]     <= sr_tag[i-1];
            sr_special[i] <= sr_special[i-1];
            sr_res[i]     <= sr_res[i-1];
            sr_flags[i]   <= sr_flags[i-1];
        end
    end

    // -----------------------------------------------------------------------
    // Pipeline exit: special ops use their precomputed result; ordinary ops
    // take div_res and flag an infinite exponent as overflow and a nonzero
    // zero-exponent value as underflow (both inexact).
    // -----------------------------------------------------------------------
    assign ex_valid = sr_valid[DIV_LAT-1];
    assign ex_tag   = sr_tag[DIV_LAT-1];

    always_comb begin
        ex_res   = div_res;
        ex_flags = '0;
        if (sr_special[DIV_LAT-1]) begin
            ex_res   = sr_res[DIV_LAT-1];
            ex_flags = sr_flags[DIV_LAT-1];
        end else if (&div_res[30:23]) begin
            ex_flags[F_OF] = 1'b1;
            ex_flags[F_NX] = 1'b1;
        end else if ((~|div_res[30:23]) && (|div_res[30:0])) begin
            ex_flags[F_UF] = 1'b1;
            ex_flags[F_NX] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // In-flight counter: +1 on accept, -1 when a valid op leaves the shift
    // register, unchanged when both happen together.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            inflight_cnt <= '0;
        end else begin
            case ({accept, ex_valid})
                2'b10:   inflight_cnt <= inflight_cnt + ONE_CNT;
                2'b01:   inflight_cnt <= inflight_cnt - ONE_CNT;
                default: inflight_cnt <= inflight_cnt;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Result buffer control. A push into a full buffer is still legal when
    // the head is popped in the same cycle. Flush voids both push and pop.
    // -----------------------------------------------------------------------
    assign obuf_full = (obuf_cnt == DEPTH_CNT);
    assign out_valid = rst && (obuf_cnt != '0);
    assign pop       = out_valid && out_ready && !flush;
    assign push      = ex_valid && !flush && (!obuf_full || pop);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            obuf_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            case ({push, pop})
                2'b10:   obuf_cnt <= obuf_cnt + ONE_CNT;
                2'b01:   obuf_cnt <= obuf_cnt - ONE_CNT;
                default: obuf_cnt <= obuf_cnt;
            endcase
        end
    end

    // Buffer storage; contents are only visible through out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_res[wr_ptr]   <= ex_res;
            mem_tag[wr_ptr]   <= ex_tag;
            mem_flags[wr_ptr] <= ex_flags;
        end
    end

    // -----------------------------------------------------------------------
    // Head outputs are forced to zero whenever nothing valid is presented,
    // which also covers the reset-asserted cycles.
    // -----------------------------------------------------------------------
    assign out_res    = out_valid ? mem_res[rd_ptr]   : '0;
    assign out_tag    = out_valid ? mem_tag[rd_ptr]   : '0;
    assign out_fflags = out_valid ? mem_flags[rd_ptr] : '0;

endmodule

// File: tb/tb_fdiv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fdiv_seq_ctrl
//
// Self-checking bench for fdiv_seq_ctrl with default parameters. A stand-in
// divider delays a bench-chosen result by DIV_LAT cycles so that ordinary ops
// return known values. Single-op vectors come from a table; credit, ordering,
// flush and reset behaviour are covered by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_fdiv_seq_ctrl;

    localparam int DIV_LAT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_res;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [4:0]  out_tag;
    logic [4:0]  out_fflags;

    // Value the stand-in divider returns for the operands presented now.
    logic [31:0] div_plan;
    logic [31:0] plan_pipe [DIV_LAT];

    int vectors_applied = 0;
    int miscompares     = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] plan;
        logic [31:0] res;
        logic [4:0]  flags;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    fdiv_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_res    (div_res),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_tag    (out_tag),
        .out_fflags (out_fflags)
    );

    always #5 clk = ~clk;

    // Stand-in divider: fixed latency, free-running.
    initial begin
        for (int i = 0; i < DIV_LAT; i++) plan_pipe[i] = '0;
    end

    always @(posedge clk) begin
        plan_pipe[0] <= div_plan;
        for (int i = 1; i < DIV_LAT; i++) plan_pipe[i] <= plan_pipe[i-1];
    end

    assign div_res = plan_pipe[DIV_LAT-1];

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        vectors_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %h, expected %h", name, act, exp);
        end
    endtask

    // Each cycle begins 1 time unit after the rising edge; inputs are driven
    // there and outputs are sampled one more unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tag, input logic [31:0] plan);
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        div_plan = plan;
    endtask

    // One isolated op: accept in cycle 0, result visible in cycle 6, popped.
    task automatic apply_stimulus(input vec_t v, input int idx);
        in_valid = 1'b1;
        drive_op(v.a, v.b, v.tag, v.plan);
        settle();
        check_output($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'd1);
        check_output($sformatf("v%0d div_a", idx), div_a, v.a);
        check_output($sformatf("v%0d div_b", idx), div_b, v.b);
        next_cycle();
        in_valid = 1'b0;
        repeat (4) next_cycle();
        settle();
        check_output($sformatf("v%0d early valid", idx), 32'(out_valid), 32'd0);
        next_cycle();
        out_ready = 1'b1;
        settle();
        check_output($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'd1);
        check_output($sformatf("v%0d out_res", idx), out_res, v.res);
        check_output($sformatf("v%0d out_tag", idx), 32'(out_tag), 32'(v.tag));
        check_output($sformatf("v%0d out_fflags", idx), 32'(out_fflags), 32'(v.flags));
        next_cycle();
        out_ready = 1'b0;
        settle();
        check_output($sformatf("v%0d popped", idx), 32'(out_valid), 32'd0);
        next_cycle();
    endtask

    initial begin
        //           a             b             tag    plan          res           flags
        vecs[0]  = '{32'h40400000, 32'h40000000, 5'd3,  32'h3FC00000, 32'h3FC00000, 5'b00000};
        vecs[1]  = '{32'h3F800000, 32'h80000000, 5'd1,  32'hDEADBEEF, 32'hFF800000, 5'b01000};
        vecs[2]  = '{32'h00000000, 32'h00000000, 5'd2,  32'h12345678, 32'h7FC00000, 5'b10000};
        vecs[3]  = '{32'h7F800001, 32'h3F800000, 5'd4,  32'h12345678, 32'h7FC00000, 5'b10000};
        vecs[4]  = '{32'h7FC00001, 32'h3F800000, 5'd5,  32'h12345678, 32'h7FC00000, 5'b00000};
        vecs[5]  = '{32'h7F800000, 32'hFF800000, 5'd6,  32'h12345678, 32'h7FC00000, 5'b10000};
        vecs[6]  = '{32'h7F800000, 32'hC0000000, 5'd7,  32'h12345678, 32'hFF800000, 5'b00000};
        vecs[7]  = '{32'h40000000, 32'hFF800000, 5'd8,  32'h12345678, 32'h80000000, 5'b00000};
        vecs[8]  = '{32'h80000000, 32'hC0400000, 5'd9,  32'h12345678, 32'h00000000, 5'b00000};
        vecs[9]  = '{32'h00000001, 32'h00000000, 5'd10, 32'h12345678, 32'h7FC00000, 5'b10000};
        vecs[10] = '{32'h3F800000, 32'h80000001, 5'd11, 32'h12345678, 32'hFF800000, 5'b01000};
        vecs[11] = '{32'h7F000000, 32'h00800000, 5'd12, 32'h7F800000, 32'h7F800000, 5'b00101};
        vecs[12] = '{32'h00800000, 32'h4B000000, 5'd13, 32'h00000010, 32'h00000010, 5'b00011};
        vecs[13] = '{32'h3F800000, 32'hBF800000, 5'd14, 32'h80000000, 32'h80000000, 5'b00000};
        vecs[14] = '{32'h7F800000, 32'h00000000, 5'd15, 32'h12345678, 32'h7F800000, 5'b00000};
        vecs[15] = '{32'h3F800000, 32'hFF800001, 5'd31, 32'h12345678, 32'h7FC00000, 5'b10000};

        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_op(32'h0, 32'h0, 5'd0, 32'h0);

        // ---------------- Reset state ----------------
        repeat (2) next_cycle();
        in_valid = 1'b1;
        settle();
        check_output("reset in_ready", 32'(in_ready), 32'd0);
        check_output("reset out_valid", 32'(out_valid), 32'd0);
        check_output("reset out_res", out_res, 32'd0);
        check_output("reset out_tag", 32'(out_tag), 32'd0);
        check_output("reset out_fflags", 32'(out_fflags), 32'd0);
        next_cycle();
        rst      = 1'b1;
        in_valid = 1'b0;
        settle();
        check_output("release in_ready", 32'(in_ready), 32'd1);
        next_cycle();

        // ---------------- Single-op table ----------------
        for (int i = 0; i < NVEC; i++) apply_stimulus(vecs[i], i);

        // ---------------- Credit exhaustion then drain ----------------
        // Op k (k<4) is offered in cycle k; from cycle 4 a fifth op is held.
        for (int c = 0; c < 12; c++) begin
            int k;
            k = (c < 4) ? c : 4;
            in_valid  = 1'b1;
            out_ready = 1'b0;
            drive_op(32'h40400000, 32'h40000000, 5'(20 + k), 32'h3F100000 + 32'(k));
            settle();
            check_output($sformatf("credit c%0d in_ready", c), 32'(in_ready),
                         (c < 4) ? 32'd1 : 32'd0);
            if (c >= 6) begin
                check_output($sformatf("credit c%0d hold valid", c), 32'(out_valid), 32'd1);
                check_output($sformatf("credit c%0d hold tag", c), 32'(out_tag), 32'd20);
                check_output($sformatf("credit c%0d hold res", c), out_res, 32'h3F100000);
            end
            next_cycle();
        end
        for (int c = 12; c < 16; c++) begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
            settle();
            check_output($sformatf("drain c%0d valid", c), 32'(out_valid), 32'd1);
            check_output($sformatf("drain c%0d tag", c), 32'(out_tag), 32'(20 + c - 12));
            check_output($sformatf("drain c%0d res", c), out_res, 32'h3F100000 + 32'(c - 12));
            check_output($sformatf("drain c%0d in_ready", c), 32'(in_ready),
                         (c == 12) ? 32'd0 : 32'd1);
            next_cycle();
        end
        out_ready = 1'b0;
        settle();
        check_output("drain empty", 32'(out_valid), 32'd0);
        next_cycle();

        // ---------------- Sustained stream across pointer wrap ----------------
        // Credits return 7 cycles after accept, so accepts land in cycles with
        // (c mod 7) < 4 and each result is shown (and popped) 6 cycles later.
        begin
            int op_next;
            int out_idx;
            op_next = 0;
            out_idx = 0;
            for (int c = 0; c < 24; c++) begin
                logic exp_rdy;
                logic exp_vld;
                in_valid  = (op_next < 12);
                out_ready = 1'b1;
                drive_op(32'h40400000, 32'h40000000, 5'(op_next),
                         32'h3F200000 + 32'(op_next));
                settle();
                exp_rdy = ((c % 7) < 4);
                exp_vld = (c >= 6) && (((c - 6) % 7) < 4);
                check_output($sformatf("stream c%0d in_ready", c), 32'(in_ready), 32'(exp_rdy));
                check_output($sformatf("stream c%0d out_valid", c), 32'(out_valid), 32'(exp_vld));
                if (exp_vld) begin
                    check_output($sformatf("stream c%0d tag", c), 32'(out_tag), 32'(out_idx));
                    check_output($sformatf("stream c%0d res", c), out_res,
                                 32'h3F200000 + 32'(out_idx));
                    out_idx++;
                end
                if (exp_rdy && in_valid) op_next++;
                next_cycle();
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            settle();
            check_output("stream drained", 32'(out_valid), 32'd0);
            next_cycle();
        end

        // ---------------- Flush with ops buffered and in flight ----------------
        for (int c = 0; c < 7; c++) begin
            in_valid  = (c == 0) || (c == 1) || (c == 5) || (c == 6);
            out_ready = 1'b0;
            drive_op(32'h3F800000, 32'h00000000, 5'(c + 1), 32'h0);
            settle();
            if (in_valid)
                check_output($sformatf("flush c%0d in_ready", c), 32'(in_ready), 32'd1);
            next_cycle();
        end
        flush     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive_op(32'h3F800000, 32'h00000000, 5'd30, 32'h0);
        settle();
        check_output("flush cycle in_ready", 32'(in_ready), 32'd0);
        check_output("flush cycle head valid", 32'(out_valid), 32'd1);
        check_output("flush cycle head tag", 32'(out_tag), 32'd1);
        next_cycle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        settle();
        check_output("post flush in_ready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 10; c++) begin
            check_output($sformatf("post flush c%0d valid", c), 32'(out_valid), 32'd0);
            next_cycle();
            settle();
        end
        next_cycle();

        // ---------------- Reset pulse with ops in flight ----------------
        for (int c = 0; c < 7; c++) begin
            in_valid  = (c < 2);
            out_ready = 1'b0;
            drive_op(32'h3F800000, 32'h80000000, 5'(c + 5), 32'h0);
            settle();
            if (c == 6) begin
                check_output("prereset valid", 32'(out_valid), 32'd1);
                check_output("prereset tag", 32'(out_tag), 32'd5);
            end
            next_cycle();
        end
        rst       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        settle();
        check_output("midreset in_ready", 32'(in_ready), 32'd0);
        check_output("midreset out_valid", 32'(out_valid), 32'd0);
        check_output("midreset out_res", out_res, 32'd0);
        check_output("midreset out_tag", 32'(out_tag), 32'd0);
        check_output("midreset out_fflags", 32'(out_fflags), 32'd0);
        next_cycle();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        settle();
        check_output("postreset in_ready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 10; c++) begin
            check_output($sformatf("postreset c%0d valid", c), 32'(out_valid), 32'd0);
            next_cycle();
            settle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
